sys1_rom_loader: RTL and testbench
==================================

SYS1_ROM_LOADER -- requirements
Module: sys1_rom_loader

Interface
REQ-001 SHALL have parameter MIN_BYTES, default 25'h0C000: minimum index-0 byte count for a valid ROM image.
REQ-002 SHALL have parameter HOLD_CYCLES, default 1024: core-reset hold after a valid download; range 1..65535.
REQ-003 SHALL have port clk  in  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have ports ioctl_download in 1, ioctl_wr in 1, ioctl_index in 8, ioctl_addr in 25, ioctl_dout in 8: HPS download stream.
REQ-006 SHALL have ports rom_addr out 25, rom_data out 8, rom_we out 1: registered ROM write stream to the game core.
REQ-007 SHALL have ports sysmode out 8, dsw0 out 8, dsw1 out 8: latched config bytes.
REQ-008 SHALL have ports core_reset out 1, rom_ready out 1, load_error out 1: core control and status.
REQ-009 SHALL have ports byte_count out 25, checksum out 8: last ROM download statistics.

Function
REQ-010 SHALL implement states IDLE, LOAD, HOLD, RUN; dl_start = ioctl_download & ~dl_prev & ioctl_index==0, where dl_prev is ioctl_download registered.
REQ-011 IDLE/HOLD/RUN: on dl_start -> LOAD; clear byte_count, checksum, rom_ready, load_error that edge.
REQ-012 LOAD: ioctl_download low -> HOLD if byte_count >= MIN_BYTES, else -> IDLE with load_error=1.
REQ-013 HOLD: hold counter cleared on entry; increments each cycle; after exactly HOLD_CYCLES cycles in HOLD -> RUN; rom_ready=1 on RUN entry.
REQ-014 core_reset SHALL be 1 in IDLE, LOAD, HOLD; 0 only in RUN.
REQ-015 Forwarded write: ioctl_wr & ioctl_download & ioctl_index==0 while in LOAD, or in the dl_start cycle itself.
REQ-016 Each forwarded write SHALL produce rom_we=1 for exactly one cycle, one cycle later, with rom_addr/rom_data = ioctl_addr/ioctl_dout of the write cycle.
REQ-017 rom_addr and rom_data SHALL hold last values while rom_we=0.
REQ-018 byte_count SHALL increment by 1 per forwarded write, saturating at 25'h1FFFFFF; updates same edge as rom_we assertion.
REQ-019 checksum SHALL be the modulo-256 sum of forwarded ioctl_dout bytes.
REQ-020 Writes with ioctl_download=0, or index-0 writes outside LOAD except the dl_start cycle, SHALL be ignored.
REQ-021 ioctl_wr & ioctl_index==1 & ioctl_addr==0 SHALL load sysmode next edge, in any state.
REQ-022 ioctl_wr & ioctl_index==254 & ioctl_addr[24:1]==0 SHALL load dsw0 (addr 0) or dsw1 (addr 1) next edge, in any state; other 254 addresses ignored.
REQ-023 Config writes (index 1/254) SHALL NOT change state, byte_count, checksum or rom_we.
REQ-024 Index change during LOAD SHALL NOT abort LOAD; only ioctl_download falling ends it.
REQ-025 load_error SHALL stay 1 until next dl_start or reset.

Reset
REQ-026 reset SHALL force IDLE, rom_we=0, core_reset=1, rom_ready=0, load_error=0, byte_count=0, checksum=0, rom_addr=0, rom_data=0, hold counter=0, dl_prev=0.
REQ-027 sysmode, dsw0, dsw1 SHALL power up 0 and be unaffected by reset.
REQ-028 reset mid-LOAD SHALL abort; with ioctl_download still high after reset, no dl_start occurs (dl_prev becomes 1), remaining writes ignored, state stays IDLE.
REQ-029 reset has priority over every simultaneous event, including dl_start and config writes.

Verification
REQ-030 Download 0x0C000 bytes index 0, data=addr[7:0] -> 0x0C000 single-cycle rom_we pulses, byte_count=0x0C000, checksum=0x00, RUN exactly 1024 cycles after download falls, core_reset 0, rom_ready 1.
REQ-031 Download 0x100 bytes index 0 -> IDLE, load_error=1, core_reset=1, rom_ready=0; byte_count=0x100.
REQ-032 In RUN, index 254 writes addr0=0xA5, addr1=0x3C, addr5=0xFF -> dsw0=0xA5, dsw1=0x3C, state RUN, rom_we never asserted.
REQ-033 ioctl_wr coincident with dl_start, addr 0 data 0x7E -> rom_we next cycle, rom_addr=0, rom_data=0x7E, byte_count=1.
REQ-034 reset pulsed after 50 of 0x0C000 bytes, download continues -> IDLE, no further rom_we, byte_count=0, sysmode unchanged.
REQ-035 Second valid download started in RUN -> core_reset rises on dl_start edge, rom_ready cleared, new checksum from new data only.

Source files
------------

// File: rtl/sys1_rom_loader.sv
// sys1_rom_loader: watches the HPS ioctl download stream. It forwards index-0
// ROM bytes to the game core as a registered write stream, keeps byte-count and
// checksum statistics, latches the sysmode and DIP-switch config bytes, and
// holds the core in reset until a ROM image of sufficient size has been loaded.
module sys1_rom_loader #(
   parameter logic [24:0] MIN_BYTES   = 25'h0C000,
   parameter int unsigned HOLD_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_index,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [24:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        rom_we,
   output logic [7:0]  sysmode,
   output logic [7:0]  dsw0,
   output logic [7:0]  dsw1,
   output logic        core_reset,
   output logic        rom_ready,
   output logic        load_error,
   output logic [24:0] byte_count,
   output logic [7:0]  checksum
);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

   localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
   localparam logic [24:0] COUNT_MAX  = 25'h1FFFFFF;

   state_t      state_q, state_d;
   logic        dl_prev_q;
   logic        dl_armed_q, dl_armed_d;
   logic [15:0] hold_cnt_q, hold_cnt_d;
   logic        rom_we_q, rom_we_d;
   logic [24:0] rom_addr_q, rom_addr_d;
   logic [7:0]  rom_data_q, rom_data_d;
   logic        core_reset_q, core_reset_d;
   logic        rom_ready_q, rom_ready_d;
   logic        load_error_q, load_error_d;
   logic [24:0] byte_count_q, byte_count_d;
   logic [7:0]  checksum_q, checksum_d;

   // Config bytes are never reset, so they start from a power-up value instead.
   logic [7:0]  sysmode_q = 8'h00;
   logic [7:0]  dsw0_q    = 8'h00;
   logic [7:0]  dsw1_q    = 8'h00;
   logic [7:0]  sysmode_d, dsw0_d, dsw1_d;

   logic        dl_start;
   logic        fwd_wr;
   logic [24:0] count_base;
   logic [7:0]  sum_base;

   // Next-state logic for the loader FSM, the forwarded write stream and the stats.
   // dl_armed_q blocks a false start when reset is released with a download
   // already in progress: a start is only recognised after download has been seen low.
   always_comb begin
      dl_start = ioctl_download & ~dl_prev_q & dl_armed_q & (ioctl_index == 8'd0);
      fwd_wr   = ioctl_wr & ioctl_download & (ioctl_index == 8'd0)
                 & ((state_q == LOAD) | dl_start);

      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      load_error_d = load_error_q;
      dl_armed_d   = dl_armed_q | ~ioctl_download;

      case (state_q)
         LOAD: begin
            if (!ioctl_download) begin
               if (byte_count_q >= MIN_BYTES) begin
                  state_d    = HOLD;
                  hold_cnt_d = 16'd0;
               end else begin
                  state_d      = IDLE;
                  load_error_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (dl_start) begin
               state_d      = LOAD;
               load_error_d = 1'b0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + 16'd1;
            end
         end
         default: begin
            if (dl_start) begin
               state_d      = LOAD;
               load_error_d = 1'b0;
            end
         end
      endcase

      count_base = dl_start ? 25'd0 : byte_count_q;
      sum_base   = dl_start ? 8'd0  : checksum_q;

      byte_count_d = count_base;
      checksum_d   = sum_base;
      rom_we_d     = fwd_wr;
      rom_addr_d   = rom_addr_q;
      rom_data_d   = rom_data_q;
      if (fwd_wr) begin
         if (count_base != COUNT_MAX) begin
            byte_count_d = count_base + 25'd1;
         end
         checksum_d = sum_base + ioctl_dout;
         rom_addr_d = ioctl_addr;
         rom_data_d = ioctl_dout;
      end

      core_reset_d = (state_d != RUN);
      rom_ready_d  = (state_d == RUN);
   end

   // Loader FSM and all of its registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         dl_prev_q    <= 1'b0;
         dl_armed_q   <= ~ioctl_download;
         hold_cnt_q   <= 16'd0;
         rom_we_q     <= 1'b0;
         rom_addr_q   <= 25'd0;
         rom_data_q   <= 8'd0;
         core_reset_q <= 1'b1;
         rom_ready_q  <= 1'b0;
         load_error_q <= 1'b0;
         byte_count_q <= 25'd0;
         checksum_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         dl_prev_q    <= ioctl_download;
         dl_armed_q   <= dl_armed_d;
         hold_cnt_q   <= hold_cnt_d;
         rom_we_q     <= rom_we_d;
         rom_addr_q   <= rom_addr_d;
         rom_data_q   <= rom_data_d;
         core_reset_q <= core_reset_d;
         rom_ready_q  <= rom_ready_d;
         load_error_q <= load_error_d;
         byte_count_q <= byte_count_d;
         checksum_q   <= checksum_d;
      end
   end

   // Config byte decode: index 1 addr 0 is sysmode, index 254 addr 0/1 are the DIP banks.
   always_comb begin
      sysmode_d = sysmode_q;
      dsw0_d    = dsw0_q;
      dsw1_d    = dsw1_q;
      if (ioctl_wr && !reset) begin
         if (ioctl_index == 8'd1 && ioctl_addr == 25'd0) begin
            sysmode_d = ioctl_dout;
         end
         if (ioctl_index == 8'd254 && ioctl_addr[24:1] == 24'd0) begin
            if (ioctl_addr[0]) begin
               dsw1_d = ioctl_dout;
            end else begin
               dsw0_d = ioctl_dout;
            end
         end
      end
   end

   // Config registers survive reset; reset only suppresses a coincident write.
   always_ff @(posedge clk) begin
      sysmode_q <= sysmode_d;
      dsw0_q    <= dsw0_d;
      dsw1_q    <= dsw1_d;
   end

   assign rom_addr   = rom_addr_q;
   assign rom_data   = rom_data_q;
   assign rom_we     = rom_we_q;
   assign sysmode    = sysmode_q;
   assign dsw0       = dsw0_q;
   assign dsw1       = dsw1_q;
   assign core_reset = core_reset_q;
   assign rom_ready  = rom_ready_q;
   assign load_error = load_error_q;
   assign byte_count = byte_count_q;
   assign checksum   = checksum_q;

endmodule

// File: tb/tb_sys1_rom_loader.sv
// Directed testbench for sys1_rom_loader. MIN_BYTES is scaled down to keep the
// run short; HOLD_CYCLES keeps its default of 1024.
module tb_sys1_rom_loader;

   localparam logic [24:0] MIN  = 25'h200;
   localparam int          HOLD = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic [24:0] ioctl_addr = 25'd0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic [24:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rom_we;
   logic [7:0]  sysmode, dsw0, dsw1;
   logic        core_reset, rom_ready, load_error;
   logic [24:0] byte_count;
   logic [7:0]  checksum;

   int errors = 0;
   int checks = 0;
   int we_count = 0;

   sys1_rom_loader #(.MIN_BYTES(MIN), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .reset(reset),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .rom_addr(rom_addr), .rom_data(rom_data), .rom_we(rom_we),
      .sysmode(sysmode), .dsw0(dsw0), .dsw1(dsw1),
      .core_reset(core_reset), .rom_ready(rom_ready), .load_error(load_error),
      .byte_count(byte_count), .checksum(checksum)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rom_we === 1'b1) we_count++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Writes bytes first..first+n-1, each followed by an idle cycle, checking every
   // rom_we pulse lasts one cycle and rom_addr/rom_data hold through the gap.
   task automatic run_download(input int first, input int n, input bit const_data, output int bad);
      logic [7:0] d;
      bad = 0;
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      for (int i = first; i < first + n; i++) begin
         d = const_data ? 8'h01 : i[7:0];
         ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = d;
         step();
         if (rom_we !== 1'b1 || rom_addr !== 25'(i) || rom_data !== d) bad++;
         ioctl_wr = 1'b0; ioctl_addr = 25'h1ABCDE; ioctl_dout = ~d;
         step();
         if (rom_we !== 1'b0 || rom_addr !== 25'(i) || rom_data !== d) bad++;
      end
   endtask

   // Drops download after a valid image and checks the core is held for exactly HOLD cycles.
   task automatic check_hold(input string tag);
      ioctl_download = 1'b0;
      step();
      repeat (HOLD - 1) step();
      checks++;
      if (core_reset !== 1'b1 || rom_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_hold_last: core_reset=%b rom_ready=%b expected 1/0", tag, core_reset, rom_ready);
      end
      step();
      checks++;
      if (core_reset !== 1'b0 || rom_ready !== 1'b1 || load_error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_run_entry: core_reset=%b rom_ready=%b load_error=%b expected 0/1/0",
                  tag, core_reset, rom_ready, load_error);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (core_reset !== 1'b1 || rom_ready !== 1'b0 || load_error !== 1'b0 || rom_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: core_reset=%b rom_ready=%b load_error=%b rom_we=%b expected 1/0/0/0",
                  core_reset, rom_ready, load_error, rom_we);
      end
      checks++;
      if (byte_count !== 25'd0 || checksum !== 8'd0 || rom_addr !== 25'd0 || rom_data !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_stats: byte_count=%h checksum=%h rom_addr=%h rom_data=%h expected all 0",
                  byte_count, checksum, rom_addr, rom_data);
      end
      checks++;
      if (sysmode !== 8'd0 || dsw0 !== 8'd0 || dsw1 !== 8'd0) begin
         errors++;
         $display("[TB] FAIL powerup_cfg: sysmode=%h dsw0=%h dsw1=%h expected 00", sysmode, dsw0, dsw1);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_valid_download();
      int bad;
      int we0;
      we0 = we_count;
      run_download(0, int'(MIN), 1'b0, bad);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("[TB] FAIL valid_stream: bad_cycles=%0d expected 0", bad);
      end
      checks++;
      if (we_count - we0 !== int'(MIN)) begin
         errors++;
         $display("[TB] FAIL valid_we_pulses: got %0d expected %0d", we_count - we0, MIN);
      end
      checks++;
      if (byte_count !== MIN || checksum !== 8'h00 || core_reset !== 1'b1) begin
         errors++;
         $display("[TB] FAIL valid_stats: byte_count=%h checksum=%h core_reset=%b expected %h/00/1",
                  byte_count, checksum, core_reset, MIN);
      end
      check_hold("valid");
   endtask

   task automatic test_config();
      int we0;
      we0 = we_count;
      ioctl_download = 1'b0;
      ioctl_wr = 1'b1;
      ioctl_index = 8'd254; ioctl_addr = 25'd0; ioctl_dout = 8'hA5; step();
      ioctl_addr = 25'd1; ioctl_dout = 8'h3C; step();
      ioctl_addr = 25'd5; ioctl_dout = 8'hFF; step();
      ioctl_index = 8'd1; ioctl_addr = 25'd0; ioctl_dout = 8'h42; step();
      ioctl_addr = 25'd1; ioctl_dout = 8'h77; step();
      ioctl_index = 8'd0; ioctl_addr = 25'd7; ioctl_dout = 8'h55; step();
      ioctl_wr = 1'b0;
      step();
      checks++;
      if (dsw0 !== 8'hA5 || dsw1 !== 8'h3C || sysmode !== 8'h42) begin
         errors++;
         $display("[TB] FAIL cfg_values: dsw0=%h dsw1=%h sysmode=%h expected A5/3C/42", dsw0, dsw1, sysmode);
      end
      checks++;
      if (we_count !== we0 || core_reset !== 1'b0 || rom_ready !== 1'b1 || byte_count !== MIN) begin
         errors++;
         $display("[TB] FAIL cfg_no_side_effect: we_pulses=%0d core_reset=%b rom_ready=%b byte_count=%h expected 0/0/1/%h",
                  we_count - we0, core_reset, rom_ready, byte_count, MIN);
      end
   endtask

   task automatic test_second_download();
      int bad;
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h01;
      step();
      checks++;
      if (core_reset !== 1'b1 || rom_ready !== 1'b0 || byte_count !== 25'd1 || checksum !== 8'h01) begin
         errors++;
         $display("[TB] FAIL second_start: core_reset=%b rom_ready=%b byte_count=%h checksum=%h expected 1/0/1/01",
                  core_reset, rom_ready, byte_count, checksum);
      end
      ioctl_wr = 1'b0;
      step();
      run_download(1, int'(MIN) + 2, 1'b1, bad);
      checks++;
      if (bad !== 0 || byte_count !== MIN + 25'd3 || checksum !== 8'h03) begin
         errors++;
         $display("[TB] FAIL second_stats: bad_cycles=%0d byte_count=%h checksum=%h expected 0/%h/03",
                  bad, byte_count, checksum, MIN + 25'd3);
      end
      check_hold("second");
   endtask

   task automatic test_short_download(input int n, input logic [7:0] exp_sum, input string tag);
      int bad;
      run_download(0, n, 1'b0, bad);
      ioctl_download = 1'b0;
      step();
      checks++;
      if (load_error !== 1'b1 || core_reset !== 1'b1 || rom_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_error: load_error=%b core_reset=%b rom_ready=%b expected 1/1/0",
                  tag, load_error, core_reset, rom_ready);
      end
      checks++;
      if (byte_count !== 25'(n) || checksum !== exp_sum) begin
         errors++;
         $display("[TB] FAIL %s_stats: byte_count=%h checksum=%h expected %h/%h", tag, byte_count, checksum, n, exp_sum);
      end
      repeat (HOLD + 4) step();
      checks++;
      if (core_reset !== 1'b1 || load_error !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s_stays_idle: core_reset=%b load_error=%b expected 1/1", tag, core_reset, load_error);
      end
   endtask

   task automatic test_coincident_and_index_change();
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h7E;
      step();
      checks++;
      if (rom_we !== 1'b1 || rom_addr !== 25'd0 || rom_data !== 8'h7E || byte_count !== 25'd1
          || checksum !== 8'h7E || load_error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL coincident: we=%b addr=%h data=%h count=%h sum=%h err=%b expected 1/0/7E/1/7E/0",
                  rom_we, rom_addr, rom_data, byte_count, checksum, load_error);
      end
      ioctl_wr = 1'b0; ioctl_addr = 25'h0F0F0; ioctl_dout = 8'h99;
      step();
      checks++;
      if (rom_we !== 1'b0 || rom_addr !== 25'd0 || rom_data !== 8'h7E) begin
         errors++;
         $display("[TB] FAIL rom_hold: we=%b addr=%h data=%h expected 0/0/7E", rom_we, rom_addr, rom_data);
      end
      ioctl_index = 8'd254; ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h11;
      step();
      checks++;
      if (rom_we !== 1'b0 || dsw0 !== 8'h11 || byte_count !== 25'd1) begin
         errors++;
         $display("[TB] FAIL midload_cfg: we=%b dsw0=%h count=%h expected 0/11/1", rom_we, dsw0, byte_count);
      end
      ioctl_index = 8'd0; ioctl_addr = 25'd1; ioctl_dout = 8'h22;
      step();
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      step();
      checks++;
      if (load_error !== 1'b1 || byte_count !== 25'd2 || checksum !== 8'hA0) begin
         errors++;
         $display("[TB] FAIL index_change: load_error=%b count=%h sum=%h expected 1/2/A0", load_error, byte_count, checksum);
      end
   endtask

   task automatic test_reset_mid_load();
      int we_after;
      ioctl_index = 8'd0; ioctl_download = 1'b1; ioctl_wr = 1'b1;
      for (int i = 0; i < 50; i++) begin
         ioctl_addr = 25'(i); ioctl_dout = i[7:0];
         step();
      end
      checks++;
      if (byte_count !== 25'd50) begin
         errors++;
         $display("[TB] FAIL pre_reset_count: got %h expected 32", byte_count);
      end
      reset = 1'b1; ioctl_addr = 25'd50; ioctl_dout = 8'd50;
      step();
      reset = 1'b0;
      checks++;
      if (rom_we !== 1'b0 || byte_count !== 25'd0 || checksum !== 8'd0 || rom_addr !== 25'd0 || core_reset !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midload_reset: we=%b count=%h sum=%h addr=%h core_reset=%b expected 0/0/0/0/1",
                  rom_we, byte_count, checksum, rom_addr, core_reset);
      end
      we_after = 0;
      for (int i = 51; i < 71; i++) begin
         ioctl_addr = 25'(i); ioctl_dout = i[7:0];
         step();
         if (rom_we !== 1'b0) we_after++;
      end
      checks++;
      if (we_after !== 0 || byte_count !== 25'd0) begin
         errors++;
         $display("[TB] FAIL post_reset_ignored: we_cycles=%0d count=%h expected 0/0", we_after, byte_count);
      end
      checks++;
      if (sysmode !== 8'h42 || dsw0 !== 8'h11 || dsw1 !== 8'h3C) begin
         errors++;
         $display("[TB] FAIL cfg_survives_reset: sysmode=%h dsw0=%h dsw1=%h expected 42/11/3C", sysmode, dsw0, dsw1);
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      step();
      step();
      checks++;
      if (load_error !== 1'b0 || core_reset !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_left_idle: load_error=%b core_reset=%b expected 0/1", load_error, core_reset);
      end
      reset = 1'b1; ioctl_wr = 1'b1; ioctl_index = 8'd1; ioctl_addr = 25'd0; ioctl_dout = 8'h99;
      step();
      reset = 1'b0; ioctl_wr = 1'b0;
      step();
      checks++;
      if (sysmode !== 8'h42) begin
         errors++;
         $display("[TB] FAIL reset_blocks_cfg: sysmode=%h expected 42", sysmode);
      end
   endtask

   initial begin
      test_reset();
      test_valid_download();
      test_config();
      test_second_download();
      test_short_download(256, 8'h80, "short");
      test_short_download(int'(MIN) - 1, 8'h01, "min_minus_1");
      test_coincident_and_index_change();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
